regdump: RTL and testbench

REGDUMP -- requirements
Module: regdump

---
 rtl/regdump.sv | 159 +++++++++++++++
 tb/tb_regdump.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regdump.sv
// -----------------------------------------------------------------------------
// regdump -- streams a range of register-file words out as a byte stream.
//
// A dump reads registers first_addr..last_addr (inclusive, wrapping past 31
// back to 0) through a combinational read port. Each word is sent as 4 bytes,
// in MSB-first or LSB-first order, over a valid/ready byte interface.
//
// Handshake: tx_valid is high for every cycle of SEND. A byte moves on a
// rising edge where tx_valid && tx_ready are both high. While tx_valid is high
// and tx_ready is low, tx_data stays stable. Once tx_valid is raised, it is
// withdrawn only when the byte transfers, on abort, or on reset.
//
// Optional feature (macro REGDUMP_HDR_EN): each word is preceded by two header
// bytes, 0xA5 then {3'b000, rf_addr}, which makes each word 6 bytes long.
//
// Parameters
//   MSB_FIRST   1: bytes [31:24] go out first; 0: bytes [7:0] go out first
// Ports
//   DUMP_CLK    in   clock, rising edge
//   DUMP_RST_N  in   synchronous active-low reset
//   start       in   begin a dump (sampled only in IDLE)
//   first_addr  in   [4:0] first register index, captured on start
//   last_addr   in   [4:0] last register index (inclusive), captured on start
//   abort       in   cancel the dump in progress
//   rf_addr     out  [4:0] registered register-file read address
//   rf_data     in   [31:0] register-file read data (combinational)
//   tx_data     out  [7:0] outgoing byte
//   tx_valid    out  tx_data valid
//   tx_ready    in   consumer accepts the byte
//   busy        out  high in every state except IDLE
//   done        out  one-cycle pulse when a dump completes normally
// -----------------------------------------------------------------------------
module regdump #(
  parameter int MSB_FIRST = 1
) (
  input  logic        DUMP_CLK,
  input  logic        DUMP_RST_N,
  input  logic        start,
  input  logic [4:0]  first_addr,
  input  logic [4:0]  last_addr,
  input  logic        abort,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  last_q;
  logic [31:0] word_q;
  logic [2:0]  cnt_q;
  logic [7:0]  data_byte;
  logic        xfer;
  logic        shift_en;

`ifdef REGDUMP_HDR_EN
  localparam logic [2:0] LAST_BYTE = 3'd5;
  // The two header bytes do not consume any of the data word.
  assign shift_en = (cnt_q >= 3'd2);
`else
  localparam logic [2:0] LAST_BYTE = 3'd3;
  assign shift_en = 1'b1;
`endif

  // The word is shifted as bytes leave, so the byte to send always sits at
  // the same end of the shift register.
  assign data_byte = (MSB_FIRST != 0) ? word_q[31:24] : word_q[7:0];

  // Abort beats a same-cycle transfer, so a byte offered alongside abort is
  // never counted as sent.
  assign xfer     = (state == SEND) && tx_ready && !abort;
  assign tx_valid = (state == SEND);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // State register
  always_ff @(posedge DUMP_CLK) begin
    if (!DUMP_RST_N) state <= IDLE;
    else             state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = SEND;
      SEND: begin
        if (tx_ready && (cnt_q == LAST_BYTE))
          state_nxt = (rf_addr == last_q) ? DONE : FETCH;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) state_nxt = IDLE;
  end

  // Outgoing byte; forced to zero outside SEND so it reads 0 from reset.
  always_comb begin
    tx_data = 8'h00;
    if (state == SEND) begin
`ifdef REGDUMP_HDR_EN
      if (cnt_q == 3'd0)      tx_data = 8'hA5;
      else if (cnt_q == 3'd1) tx_data = {3'b000, rf_addr};
      else                    tx_data = data_byte;
`else
      tx_data = data_byte;
`endif
    end
  end

  // Datapath: address, end-address latch, shift word, byte counter
  always_ff @(posedge DUMP_CLK) begin
    if (!DUMP_RST_N) begin
      rf_addr <= 5'd0;
      last_q  <= 5'd0;
      word_q  <= 32'd0;
      cnt_q   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rf_addr <= first_addr;
            last_q  <= last_addr;
          end
        end
        FETCH: begin
          word_q <= rf_data;
          cnt_q  <= 3'd0;
        end
        SEND: begin
          if (xfer) begin
            cnt_q <= cnt_q + 3'd1;
            if (shift_en) begin
              if (MSB_FIRST != 0) word_q <= {word_q[23:0], 8'h00};
              else                word_q <= {8'h00, word_q[31:8]};
            end
            // Advance to the next word; 5-bit addition wraps 31 -> 0.
            if ((cnt_q == LAST_BYTE) && (rf_addr != last_q))
              rf_addr <= rf_addr + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regdump.sv
module tb_regdump;

`ifdef REGDUMP_HDR_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif
  localparam int BPW = 4 + HDR;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic        abort;
  logic        tx_ready;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [31:0] regs [32];

  logic [4:0]  rf_addr_m, rf_addr_l;
  logic [31:0] rf_data_m, rf_data_l;
  logic [7:0]  tx_data_m, tx_data_l;
  logic        tx_valid_m, tx_valid_l;
  logic        busy_m, busy_l;
  logic        done_m, done_l;

  assign rf_data_m = regs[rf_addr_m];
  assign rf_data_l = regs[rf_addr_l];

  regdump #(.MSB_FIRST(1)) dut_m (
    .DUMP_CLK(clk), .DUMP_RST_N(rst_n), .start(start),
    .first_addr(first_addr), .last_addr(last_addr), .abort(abort),
    .rf_addr(rf_addr_m), .rf_data(rf_data_m), .tx_data(tx_data_m),
    .tx_valid(tx_valid_m), .tx_ready(tx_ready), .busy(busy_m), .done(done_m)
  );

  regdump #(.MSB_FIRST(0)) dut_l (
    .DUMP_CLK(clk), .DUMP_RST_N(rst_n), .start(start),
    .first_addr(first_addr), .last_addr(last_addr), .abort(abort),
    .rf_addr(rf_addr_l), .rf_data(rf_data_l), .tx_data(tx_data_l),
    .tx_valid(tx_valid_l), .tx_ready(tx_ready), .busy(busy_l), .done(done_l)
  );

  // ---------------- scoreboard state ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q [$];
  logic [7:0] exp_l [$];
  logic [7:0] got_m [$];
  logic [7:0] got_l [$];
  logic [4:0] addr_m [$];
  int         done_cnt_m = 0;
  int         done_cnt_l = 0;

  // Transfer monitor: records bytes that actually move on each rising edge.
  always @(posedge clk) begin
    if (rst_n) begin
      if (tx_valid_m && tx_ready && !abort) begin
        got_m.push_back(tx_data_m);
        addr_m.push_back(rf_addr_m);
      end
      if (tx_valid_l && tx_ready && !abort) got_l.push_back(tx_data_l);
      if (done_m) done_cnt_m++;
      if (done_l) done_cnt_l++;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic clear_streams();
    exp_q.delete(); exp_l.delete();
    got_m.delete(); got_l.delete(); addr_m.delete();
  endtask

  // Expected byte sequence for one word, built from the word value.
  task automatic push_word(input logic [4:0] a, input logic [31:0] w, input bit msb);
    logic [7:0] b [4];
    b[0] = w[31:24]; b[1] = w[23:16]; b[2] = w[15:8]; b[3] = w[7:0];
    if (HDR != 0) begin
      if (msb) begin exp_q.push_back(8'hA5); exp_q.push_back({3'b000, a}); end
      else     begin exp_l.push_back(8'hA5); exp_l.push_back({3'b000, a}); end
    end
    for (int i = 0; i < 4; i++) begin
      if (msb) exp_q.push_back(b[i]);
      else     exp_l.push_back(b[3 - i]);
    end
  endtask

  // Leaves the caller at the negedge after the start edge (DUT in FETCH).
  task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
    @(negedge clk);
    first_addr = f; last_addr = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!done_m && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (!done_m) begin
      tests_failed++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int d0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b1;
    first_addr = 5'd0; last_addr = 5'd0;
    repeat (2) @(negedge clk);
    tests_run++; if (tx_valid_m !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid_m); end
    tests_run++; if (busy_m !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy_m); end
    tests_run++; if (done_m !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done_m); end
    tests_run++; if (rf_addr_m !== 5'd0) begin tests_failed++; $display("FAIL reset_rf_addr: got %0d want 0", rf_addr_m); end
    tests_run++; if (tx_data_m !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data: got %h want 00", tx_data_m); end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (busy_m !== 1'b0) begin tests_failed++; $display("FAIL reset_release_busy: got %b want 0", busy_m); end

    // Reset asserted for two cycles in the middle of SEND.
    regs[4] = 32'hCAFEF00D;
    d0 = done_cnt_m;
    start_dump(5'd4, 5'd6);
    @(negedge clk);
    tests_run++; if (tx_valid_m !== 1'b1) begin tests_failed++; $display("FAIL midreset_in_send: got tx_valid %b want 1", tx_valid_m); end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (tx_valid_m !== 1'b0) begin tests_failed++; $display("FAIL midreset_tx_valid: got %b want 0", tx_valid_m); end
    tests_run++; if (busy_m !== 1'b0) begin tests_failed++; $display("FAIL midreset_busy: got %b want 0", busy_m); end
    tests_run++; if (rf_addr_m !== 5'd0) begin tests_failed++; $display("FAIL midreset_rf_addr: got %0d want 0", rf_addr_m); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (busy_m !== 1'b0) begin tests_failed++; $display("FAIL midreset_after_busy: got %b want 0", busy_m); end
    tests_run++; if (done_cnt_m !== d0) begin tests_failed++; $display("FAIL midreset_no_done: got %0d pulses want %0d", done_cnt_m, d0); end
  endtask

  task automatic test_single_word();
    int d0;
    regs[5] = 32'h12345678;
    clear_streams();
    push_word(5'd5, 32'h12345678, 1'b1);
    tx_ready = 1'b1;
    d0 = done_cnt_m;
    start_dump(5'd5, 5'd5);
    tests_run++; if (tx_valid_m !== 1'b0 || busy_m !== 1'b1) begin tests_failed++; $display("FAIL single_fetch: got valid %b busy %b want 0 1", tx_valid_m, busy_m); end
    tests_run++; if (rf_addr_m !== 5'd5) begin tests_failed++; $display("FAIL single_rf_addr: got %0d want 5", rf_addr_m); end
    for (int i = 0; i < BPW; i++) begin
      @(negedge clk);
      tests_run++;
      if (tx_valid_m !== 1'b1 || tx_data_m !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL single_byte%0d: got valid %b data %h want 1 %h", i, tx_valid_m, tx_data_m, exp_q[i]);
      end
    end
    @(negedge clk);
    tests_run++; if (done_m !== 1'b1 || tx_valid_m !== 1'b0) begin tests_failed++; $display("FAIL single_done_pulse: got done %b valid %b want 1 0", done_m, tx_valid_m); end
    // start while in DONE must be ignored.
    first_addr = 5'd2; last_addr = 5'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests_run++; if (done_m !== 1'b0 || busy_m !== 1'b0) begin tests_failed++; $display("FAIL single_after_done: got done %b busy %b want 0 0", done_m, busy_m); end
    tests_run++; if (rf_addr_m !== 5'd5) begin tests_failed++; $display("FAIL single_start_in_done: got rf_addr %0d want 5", rf_addr_m); end
    tests_run++; if (got_m.size() != BPW) begin tests_failed++; $display("FAIL single_count: got %0d bytes want %0d", got_m.size(), BPW); end
    tests_run++; if (done_cnt_m != d0 + 1) begin tests_failed++; $display("FAIL single_done_count: got %0d want %0d", done_cnt_m - d0, 1); end
  endtask

  task automatic test_wrap();
    logic [4:0] seq [4];
    seq[0] = 5'd30; seq[1] = 5'd31; seq[2] = 5'd0; seq[3] = 5'd1;
    for (int i = 0; i < 32; i++) regs[i] = i;
    clear_streams();
    for (int w = 0; w < 4; w++) push_word(seq[w], {27'd0, seq[w]}, 1'b1);
    tx_ready = 1'b1;
    start_dump(5'd30, 5'd1);
    wait_done(100, "wrap");
    tests_run++; if (got_m.size() != 4 * BPW) begin tests_failed++; $display("FAIL wrap_count: got %0d bytes want %0d", got_m.size(), 4 * BPW); end
    if (got_m.size() == 4 * BPW) begin
      tests_run++; if (got_m[4 * BPW - 1] !== 8'h01) begin tests_failed++; $display("FAIL wrap_last_byte: got %h want 01", got_m[4 * BPW - 1]); end
      for (int w = 0; w < 4; w++) begin
        tests_run++;
        if (addr_m[w * BPW] !== seq[w]) begin
          tests_failed++;
          $display("FAIL wrap_addr%0d: got %0d want %0d", w, addr_m[w * BPW], seq[w]);
        end
      end
      for (int i = 0; i < 4 * BPW; i++) begin
        tests_run++;
        if (got_m[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL wrap_byte%0d: got %h want %h", i, got_m[i], exp_q[i]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n;
    regs[7] = 32'h12345678;
    clear_streams();
    push_word(5'd7, 32'h12345678, 1'b1);
    push_word(5'd7, 32'h12345678, 1'b0);
    tx_ready = 1'b1;
    start_dump(5'd7, 5'd7);
    n = 0;
    while (got_m.size() < HDR + 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests_run++; if (got_m.size() != HDR + 2) begin tests_failed++; $display("FAIL bp_pre_count: got %0d want %0d", got_m.size(), HDR + 2); end
    tx_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (tx_valid_m !== 1'b1 || tx_data_m !== exp_q[HDR + 2] || tx_data_l !== exp_l[HDR + 2]) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: got valid %b msb %h lsb %h want 1 %h %h",
                 c, tx_valid_m, tx_data_m, tx_data_l, exp_q[HDR + 2], exp_l[HDR + 2]);
      end
    end
    tx_ready = 1'b1;
    wait_done(20, "bp");
    tests_run++; if (got_m.size() != BPW || got_l.size() != BPW) begin tests_failed++; $display("FAIL bp_count: got %0d/%0d want %0d", got_m.size(), got_l.size(), BPW); end
    if (got_m.size() == BPW && got_l.size() == BPW) begin
      for (int i = 0; i < BPW; i++) begin
        tests_run++;
        if (got_m[i] !== exp_q[i] || got_l[i] !== exp_l[i]) begin
          tests_failed++;
          $display("FAIL bp_byte%0d: got msb %h lsb %h want %h %h", i, got_m[i], got_l[i], exp_q[i], exp_l[i]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int d0;
    int n;
    for (int i = 9; i <= 12; i++) regs[i] = 32'h0101_0101 * i;
    clear_streams();
    tx_ready = 1'b1;
    d0 = done_cnt_m;
    start_dump(5'd9, 5'd12);
    // start pulsed while busy: no restart, no address change.
    first_addr = 5'd20; last_addr = 5'd25; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests_run++; if (rf_addr_m !== 5'd9 || tx_valid_m !== 1'b1) begin tests_failed++; $display("FAIL abort_start_ignored: got rf_addr %0d valid %b want 9 1", rf_addr_m, tx_valid_m); end
    n = 0;
    while (got_m.size() < 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++; if (tx_valid_m !== 1'b0 || busy_m !== 1'b0) begin tests_failed++; $display("FAIL abort_idle: got valid %b busy %b want 0 0", tx_valid_m, busy_m); end
    tests_run++; if (got_m.size() != 2) begin tests_failed++; $display("FAIL abort_count: got %0d bytes want 2", got_m.size()); end
    repeat (8) @(negedge clk);
    tests_run++; if (done_cnt_m != d0) begin tests_failed++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt_m - d0); end
    tests_run++; if (busy_m !== 1'b0) begin tests_failed++; $display("FAIL abort_stays_idle: got busy %b want 0", busy_m); end
  endtask

`ifdef REGDUMP_HDR_EN
  task automatic test_header();
    logic [7:0] hb [6];
    hb[0] = 8'hA5; hb[1] = 8'h03; hb[2] = 8'hDE; hb[3] = 8'hAD; hb[4] = 8'hBE; hb[5] = 8'hEF;
    regs[3] = 32'hDEADBEEF;
    clear_streams();
    tx_ready = 1'b1;
    start_dump(5'd3, 5'd3);
    wait_done(30, "hdr");
    tests_run++; if (got_m.size() != 6) begin tests_failed++; $display("FAIL hdr_count: got %0d want 6", got_m.size()); end
    if (got_m.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (got_m[i] !== hb[i]) begin
          tests_failed++;
          $display("FAIL hdr_byte%0d: got %h want %h", i, got_m[i], hb[i]);
        end
      end
    end
    @(negedge clk);
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    test_reset();
    test_single_word();
    test_wrap();
    test_backpressure();
    test_abort();
`ifdef REGDUMP_HDR_EN
    test_header();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
